// File: rtl/map_pixel_fetch.sv
// map_pixel_fetch: pixel fetch and compositing stage.
// On each accepted pixel strobe, three addresses are issued back to back to a
// shared single-port sprite ROM: map, player 1, player 2. The returned words
// are composited with key-colour transparency and fixed priority
// (player 1 > player 2 > map). One 12-bit RGB pixel and its coordinates are
// produced four clocks after the strobe.
module map_pixel_fetch #(
    parameter logic [11:0] KEY_COLOR = 12'h0F0,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_stb,
    input  logic [9:0]  vga_h,
    input  logic [9:0]  vga_v,
    input  logic        valid,
    input  logic [16:0] map_addr,
    input  logic        p1_en,
    input  logic        p2_en,
    input  logic [16:0] p1_addr,
    input  logic [16:0] p2_addr,
    output logic [16:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] pixel,
    output logic        pixel_valid,
    output logic [9:0]  pix_h,
    output logic [9:0]  pix_v,
    output logic        overrun
);

    // Issue sequencer: one ROM address per cycle for the three layers.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISS_P1 = 2'd1,
        ISS_P2 = 2'd2
    } state_e;

    // Per-request fields that travel alongside the ROM data to the output.
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       valid;
        logic       p1_en;
        logic       p2_en;
    } req_t;

    state_e      state_q,    state_d;
    req_t        req_q,      req_d;
    logic [16:0] p1_addr_q,  p1_addr_d;
    logic [16:0] p2_addr_q,  p2_addr_d;
    logic [16:0] rom_addr_q, rom_addr_d;
    logic        overrun_q,  overrun_d;

    // tag_q[0]: map data on rom_data, tag_q[1]: p1 data, tag_q[2]: p2 data.
    logic [2:0]  tag_q,      tag_d;
    req_t [2:0]  stage_q,    stage_d;
    logic [11:0] map_px_q,   map_px_d;
    logic [11:0] p1_px_q,    p1_px_d;

    logic [11:0] pixel_q,    pixel_d;
    logic [9:0]  pix_h_q,    pix_h_d;
    logic [9:0]  pix_v_q,    pix_v_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [11:0] composite;

    // Issue FSM: accept a strobe in IDLE, then walk the player addresses.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        req_d      = req_q;
        p1_addr_d  = p1_addr_q;
        p2_addr_d  = p2_addr_q;
        rom_addr_d = rom_addr_q;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (pix_stb) begin
                    req_d.h     = vga_h;
                    req_d.v     = vga_v;
                    req_d.valid = valid;
                    req_d.p1_en = p1_en;
                    req_d.p2_en = p2_en;
                    p1_addr_d   = p1_addr;
                    p2_addr_d   = p2_addr;
                    rom_addr_d  = map_addr;
                    state_d     = ISS_P1;
                end
            end
            ISS_P1: begin
                rom_addr_d = p1_addr_q;
                state_d    = ISS_P2;
                // A strobe arriving mid-issue is lost; record it permanently.
                if (pix_stb) overrun_d = 1'b1;
            end
            ISS_P2: begin
                rom_addr_d = p2_addr_q;
                state_d    = IDLE;
                if (pix_stb) overrun_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture pipeline and composition; runs independently of the issuer so
    // a new request can be issued while the previous one is still returning.
    always_comb begin
        // The map address sits on rom_addr while the FSM is in ISS_P1, so its
        // data appears on rom_data one cycle later.
        tag_d   = {tag_q[1:0], (state_q == ISS_P1)};
        stage_d = {stage_q[1:0], req_q};

        map_px_d = tag_q[0] ? rom_data : map_px_q;
        p1_px_d  = tag_q[1] ? rom_data : p1_px_q;

        // First match wins; the p2 word is taken straight off rom_data.
        if (!stage_q[2].valid) begin
            composite = 12'h000;
        end else if (stage_q[2].p1_en && (p1_px_q != KEY_COLOR)) begin
            composite = p1_px_q;
        end else if (stage_q[2].p2_en && (rom_data != KEY_COLOR)) begin
            composite = rom_data;
        end else if (map_px_q != KEY_COLOR) begin
            composite = map_px_q;
        end else begin
            composite = BG_COLOR;
        end

        pixel_valid_d = tag_q[2];
        pixel_d       = pixel_q;
        pix_h_d       = pix_h_q;
        pix_v_d       = pix_v_q;
        if (tag_q[2]) begin
            pixel_d = composite;
            pix_h_d = stage_q[2].h;
            pix_v_d = stage_q[2].v;
        end
    end

    // Issue-side registers: FSM state, latched request, ROM address, overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            p1_addr_q  <= '0;
            p2_addr_q  <= '0;
            rom_addr_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            req_q      <= req_d;
            p1_addr_q  <= p1_addr_d;
            p2_addr_q  <= p2_addr_d;
            rom_addr_q <= rom_addr_d;
            overrun_q  <= overrun_d;
        end
    end

    // Capture-side registers: layer tags, travelling fields, captured pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            stage_q  <= '0;
            map_px_q <= '0;
            p1_px_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            stage_q  <= stage_d;
            map_px_q <= map_px_d;
            p1_px_q  <= p1_px_d;
        end
    end

    // Output registers: pixel and coordinates hold between updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_q       <= '0;
            pix_h_q       <= '0;
            pix_v_q       <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_q       <= pixel_d;
            pix_h_q       <= pix_h_d;
            pix_v_q       <= pix_v_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign overrun     = overrun_q;
    assign pixel       = pixel_q;
    assign pix_h       = pix_h_q;
    assign pix_v       = pix_v_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_map_pixel_fetch.sv
// Directed bench for map_pixel_fetch. The ROM model returns the low 12 bits
// of the address one clock after it is presented, so colours are chosen by
// choosing addresses. A monitor pairs every pixel_valid pulse with the
// oldest expected pixel and checks data, coordinates and latency.
module tb_map_pixel_fetch;

    logic        clk;
    logic        rst_n;
    logic        pix_stb;
    logic [9:0]  vga_h, vga_v;
    logic        valid;
    logic [16:0] map_addr, p1_addr, p2_addr;
    logic        p1_en, p2_en;
    logic [16:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] pixel;
    logic        pixel_valid;
    logic [9:0]  pix_h, pix_v;
    logic        overrun;

    localparam logic [16:0] KEY = 17'h000F0;

    map_pixel_fetch dut (
        .clk         (clk),
        .rst         (rst_n),
        .pix_stb     (pix_stb),
        .vga_h       (vga_h),
        .vga_v       (vga_v),
        .valid       (valid),
        .map_addr    (map_addr),
        .p1_en       (p1_en),
        .p2_en       (p2_en),
        .p1_addr     (p1_addr),
        .p2_addr     (p2_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pix_h       (pix_h),
        .pix_v       (pix_v),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM model with one clock of read latency.
    always @(posedge clk) rom_data <= rom_addr[11:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_count = 0;

    typedef struct {
        logic [11:0] pix;
        logic [9:0]  h;
        logic [9:0]  v;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference composite, built bottom-up from the lowest-priority layer.
    function automatic logic [11:0] model(input logic vld, input logic e1, input logic e2,
                                          input logic [16:0] ma, input logic [16:0] a1,
                                          input logic [16:0] a2);
        logic [11:0] res;
        res = 12'h000;
        if (ma[11:0] != KEY[11:0]) res = ma[11:0];
        if (e2 && a2[11:0] != KEY[11:0]) res = a2[11:0];
        if (e1 && a1[11:0] != KEY[11:0]) res = a1[11:0];
        if (!vld) res = 12'h000;
        return res;
    endfunction

    // Drive one strobe cycle (called at a negedge); returns at the next negedge.
    task automatic send(input logic [9:0] h, input logic [9:0] v, input logic vld,
                        input logic e1, input logic e2, input logic [16:0] ma,
                        input logic [16:0] a1, input logic [16:0] a2,
                        input logic accept, input logic [11:0] exp_pix);
        vga_h    = h;
        vga_v    = v;
        valid    = vld;
        p1_en    = e1;
        p2_en    = e2;
        map_addr = ma;
        p1_addr  = a1;
        p2_addr  = a2;
        pix_stb  = 1'b1;
        if (accept) exp_q.push_back('{pix: exp_pix, h: h, v: v, cyc: cyc + 5});
        @(negedge clk);
        pix_stb = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check(tag, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Output monitor: every pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (pixel_valid) begin
            exp_t e;
            pv_count++;
            if (exp_q.size() == 0) begin
                check("spurious_pv", {31'b0, pixel_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pixel",   {20'b0, pixel}, {20'b0, e.pix});
                check("pix_h",   {22'b0, pix_h}, {22'b0, e.h});
                check("pix_v",   {22'b0, pix_v}, {22'b0, e.v});
                check("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pv0;
        rst_n = 1'b0;
        pix_stb = 1'b0;
        vga_h = '0; vga_v = '0; valid = 1'b0;
        p1_en = 1'b0; p2_en = 1'b0;
        map_addr = '0; p1_addr = '0; p2_addr = '0;

        repeat (3) @(negedge clk);
        check("rst_rom_addr", {15'b0, rom_addr}, 32'd0);
        check("rst_pixel",    {20'b0, pixel}, 32'd0);
        check("rst_pv",       {31'b0, pixel_valid}, 32'd0);
        check("rst_pix_h",    {22'b0, pix_h}, 32'd0);
        check("rst_pix_v",    {22'b0, pix_v}, 32'd0);
        check("rst_overrun",  {31'b0, overrun}, 32'd0);

        // Single strobe straight after reset release; address sequence check.
        rst_n = 1'b1;
        send(10'd5, 10'd7, 1'b1, 1'b1, 1'b0, 17'd100, 17'd200, 17'd300, 1'b1, 12'd200);
        check("addr_map", {15'b0, rom_addr}, 32'd100);
        @(negedge clk);
        check("addr_p1",  {15'b0, rom_addr}, 32'd200);
        @(negedge clk);
        check("addr_p2",  {15'b0, rom_addr}, 32'd300);
        @(negedge clk);
        check("addr_hold", {15'b0, rom_addr}, 32'd300);
        drain("drain_single");
        check("pixel_hold", {20'b0, pixel}, 32'd200);
        check("pv_low",     {31'b0, pixel_valid}, 32'd0);

        // Priority and transparency, hand-computed.
        send(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 17'h00123, KEY, 17'h00F00, 1'b1, 12'hF00);
        repeat (4) @(negedge clk);
        send(10'd2, 10'd1, 1'b1, 1'b1, 1'b1, KEY, KEY, KEY, 1'b1, 12'h000);
        repeat (4) @(negedge clk);
        send(10'd3, 10'd1, 1'b0, 1'b1, 1'b1, 17'h00123, 17'h0000F, 17'h00456, 1'b1, 12'h000);
        repeat (4) @(negedge clk);
        send(10'd4, 10'd1, 1'b1, 1'b0, 1'b0, 17'h000A0, 17'h0000F, 17'h00555, 1'b1, 12'h0A0);
        repeat (4) @(negedge clk);
        send(10'd5, 10'd1, 1'b1, 1'b1, 1'b0, 17'h00321, KEY, 17'h00777, 1'b1, 12'h321);
        repeat (4) @(negedge clk);
        send(10'd6, 10'd1, 1'b1, 1'b1, 1'b1, 17'h00111, 17'h00ABC, 17'h00DEF, 1'b1, 12'hABC);
        repeat (4) @(negedge clk);
        send(10'd7, 10'd1, 1'b1, 1'b0, 1'b1, 17'h12345, 17'h00999, 17'h1F0F0, 1'b1, 12'h345);
        drain("drain_prio");

        // 640 strobes every 4 clk.
        pv0 = pv_count;
        for (int i = 0; i < 640; i++) begin
            logic [16:0] ma, a1, a2;
            logic        vld, e1, e2;
            ma  = (i % 5 == 0) ? KEY : 17'(i * 3);
            a1  = (i % 3 == 0) ? KEY : 17'(i + 'h400);
            a2  = (i % 4 == 1) ? KEY : 17'(i + 'h800);
            e1  = i[0];
            e2  = i[1];
            vld = (i % 11 != 0);
            send(10'(i), 10'((i * 7) % 480), vld, e1, e2, ma, a1, a2, 1'b1,
                 model(vld, e1, e2, ma, a1, a2));
            repeat (3) @(negedge clk);
        end
        drain("drain_line");
        check("line_count", pv_count - pv0, 640);
        check("line_overrun", {31'b0, overrun}, 32'd0);

        // Strobes 3 clk apart: sustained throughput, no mixing.
        pv0 = pv_count;
        for (int i = 0; i < 6; i++) begin
            logic [16:0] ma, a1, a2;
            ma = 17'(12'h100 + i);
            a1 = (i % 2 == 0) ? KEY : 17'(12'h200 + i);
            a2 = (i == 2) ? KEY : 17'(12'h300 + i);
            send(10'(20 + i), 10'(30 + i), 1'b1, 1'b1, (i != 4), ma, a1, a2, 1'b1,
                 model(1'b1, 1'b1, (i != 4), ma, a1, a2));
            repeat (2) @(negedge clk);
        end
        drain("drain_fast");
        check("fast_count", pv_count - pv0, 6);
        check("fast_overrun", {31'b0, overrun}, 32'd0);

        // Strobes 2 clk apart: second is dropped and flagged.
        pv0 = pv_count;
        send(10'd50, 10'd60, 1'b1, 1'b1, 1'b0, 17'h00AAA, 17'h00BBB, 17'h00CCC, 1'b1, 12'hBBB);
        @(negedge clk);
        send(10'd51, 10'd61, 1'b1, 1'b1, 1'b0, 17'h00111, 17'h00222, 17'h00333, 1'b0, 12'h000);
        check("ovr_set", {31'b0, overrun}, 32'd1);
        drain("drain_ovr");
        check("ovr_count", pv_count - pv0, 1);
        repeat (10) @(negedge clk);
        check("ovr_sticky", {31'b0, overrun}, 32'd1);

        // Reset at E2 of a request: discard it, then run a fresh one.
        pv0 = pv_count;
        send(10'd70, 10'd80, 1'b1, 1'b1, 1'b0, 17'h00123, 17'h00456, 17'h00789, 1'b0, 12'h000);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rom_addr", {15'b0, rom_addr}, 32'd0);
        check("mid_pixel",    {20'b0, pixel}, 32'd0);
        check("mid_pv",       {31'b0, pixel_valid}, 32'd0);
        check("mid_pix_h",    {22'b0, pix_h}, 32'd0);
        check("mid_pix_v",    {22'b0, pix_v}, 32'd0);
        check("mid_overrun",  {31'b0, overrun}, 32'd0);
        repeat (4) @(negedge clk);
        check("mid_no_pulse", pv_count - pv0, 0);
        rst_n = 1'b1;
        send(10'd90, 10'd91, 1'b1, 1'b0, 1'b1, 17'h00321, 17'h00654, 17'h00987, 1'b1, 12'h987);
        drain("drain_after_rst");
        check("after_rst_count", pv_count - pv0, 1);
        check("after_rst_ovr", {31'b0, overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/map_pixel_fetch.md
# map_pixel_fetch

Pixel-fetch and compositing stage between the map/player address generators and the VGA colour output. On each pixel strobe it latches the map address and both player sprite addresses. It reads all three from one shared single-port sprite ROM in consecutive clock cycles, then composites them with key-colour transparency and fixed priority. It emits one 12-bit RGB pixel per strobe, aligned with its delayed coordinates.

## Interface
- KEY_COLOR, 12'h0F0: transparent colour in sprite ROM data.
- BG_COLOR, 12'h000: colour used when all three layers are transparent.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- pix_stb  in  1  single-cycle pixel strobe. Nominally every 4 clk.
- vga_h, vga_v  in  10 each  coordinates of the pixel being requested.
- valid  in  1  pixel lies in the active display area.
- map_addr  in  17  ROM address from the map block.
- p1_en, p2_en  in  1 each  player sprite covers this pixel.
- p1_addr, p2_addr  in  17 each  player sprite ROM addresses.
- rom_addr  out  17  registered address to the sprite ROM.
- rom_data  in  12  ROM read data.
  - 1-cycle latency: data for the rom_addr value held during cycle k is valid during cycle k+1.
- pixel  out  12  composited RGB.
- pixel_valid  out  1  single-cycle strobe: pixel, pix_h and pix_v are valid.
- pix_h, pix_v  out  10 each  coordinates belonging to pixel.
- overrun  out  1  sticky error flag.

## Operation
- Issue FSM has states IDLE, ISS_P1, ISS_P2.
  - IDLE + pix_stb:
    - latch vga_h, vga_v, valid, p1_en, p2_en, p1_addr, p2_addr into a request register;
    - rom_addr <= map_addr;
    - go to ISS_P1.
  - ISS_P1: rom_addr <= latched p1_addr; go to ISS_P2.
  - ISS_P2: rom_addr <= latched p2_addr; go to IDLE.
  - rom_addr holds its last value while in IDLE.
- pix_stb is sampled only in IDLE.
  - pix_stb seen in ISS_P1 or ISS_P2 is dropped.
  - A dropped strobe sets overrun. overrun clears only on reset.
- Capture pipeline:
  - A 3-stage tag shift register tracks which layer's data is on rom_data.
  - Captures map_px, then p1_px, then p2_px on the three edges after each issue.
  - Request fields (coordinates, valid, enables) travel with the tag to the output stage.
  - The capture stage is independent of the issue FSM, so a new request may issue while the previous one is still capturing.
- Composition, evaluated at the edge that captures p2_px, first match wins:
  - 1. latched valid = 0 -> 12'h000.
  - 2. p1_en & p1_px != KEY_COLOR -> p1_px.
  - 3. p2_en & rom_data != KEY_COLOR -> rom_data (the p2 value).
  - 4. map_px != KEY_COLOR -> map_px.
  - 5. otherwise -> BG_COLOR.
- Player 1 has priority over player 2, which has priority over the map.
- Disabled players are still fetched; their data is ignored.
- Comparisons are exact 12-bit equality. No blending.

## Timing
- Strobe sampled at edge E0.
- rom_addr value by cycle:
  - map_addr during (E0,E1);
  - p1_addr during (E1,E2);
  - p2_addr during (E2,E3).
- Captures: map_px at E2, p1_px at E3, composition at E4.
- pixel, pix_h, pix_v and pixel_valid update at E4.
  - pixel_valid is high for exactly cycle (E4,E5).
  - pixel, pix_h and pix_v hold until the next output update.
  - Latency from strobe to output: 4 clk.
- Minimum strobe spacing is 3 clk.
  - A strobe at E3 issues at E3/E4/E5, outputs at E7, and does not disturb the E4 output.
  - Sustained throughput: 1 pixel per 3 clk.
- Reset (async assert, any time):
  - FSM returns to IDLE; tags and request fields are cleared.
  - rom_addr = 0, pixel = 0, pix_h = 0, pix_v = 0, pixel_valid = 0, overrun = 0.
  - A request in flight is discarded; no pixel_valid is produced for it.
- Reset deassert: the first strobe is accepted at the first edge after deassertion.

## Test plan
- Single strobe: map_addr=100, p1_addr=200, p2_addr=300, ROM returns the address's low 12 bits, valid=1, p1_en=1.
  - rom_addr must be 100, 200, 300 in cycles E0–E3.
  - At E4: pixel=12'd200, pixel_valid high for exactly 1 clk, pix_h/pix_v equal the strobed coordinates.
- Priority and transparency:
  - p1 data = KEY_COLOR, p2_en=1, p2 data=12'hF00 -> pixel=12'hF00.
  - All three layers KEY_COLOR -> BG_COLOR.
  - valid=0 -> 12'h000.
  - p1_en=0 with p1 data=12'h00F and map=12'h0A0 -> 12'h0A0.
- Back-to-back strobes every 4 clk for 640 pixels:
  - 640 pixel_valid pulses, each exactly 4 clk after its strobe;
  - coordinates in order; overrun stays 0.
- Strobes 3 clk apart:
  - outputs 3 clk apart with correct per-request data;
  - no data mixing between requests; overrun=0.
- Strobes 2 clk apart: second strobe dropped, overrun=1 and stays set; only the first pixel is output.
- rst asserted at E2 of a request:
  - all outputs read 0 immediately;
  - no pixel_valid pulse for that request;
  - a fresh strobe after release completes normally.
